// File: rtl/id_rf_pkg.sv
// Shared types for the decode / register-fetch stage: extender modes and write-back sources.
// Optional write-to-read bypass in id_rf_pipe is selected with ID_RF_BYPASS_EN.
package id_rf_pkg;

    localparam int unsigned EXT_MODE_W = 3;
    localparam int unsigned WB_SRC_W   = 2;

    typedef enum logic [EXT_MODE_W-1:0] {
        EXT_ZERO  = 3'b000,
        EXT_SIGN  = 3'b001,
        EXT_ZERO8 = 3'b010,
        EXT_SIGN8 = 3'b011,
        EXT_HIGH  = 3'b100
    } ext_mode_e;

    typedef enum logic [WB_SRC_W-1:0] {
        WB_ULA  = 2'b00,
        WB_MD   = 2'b01,
        WB_LINK = 2'b10,
        WB_ZERO = 2'b11
    } wb_src_e;

endpackage

// File: rtl/id_rf_extender.sv
// Combinational constant extender: widens the raw immediate to DATA_W according to ext_mode.
module id_rf_extender
    import id_rf_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CONST_W = 12
) (
    input  logic [EXT_MODE_W-1:0] mode_i,
    input  logic [CONST_W-1:0]    const_i,
    output logic [DATA_W-1:0]     ext_o
);

    logic [7:0] low8;

    always_comb begin
        low8  = 8'(const_i);
        ext_o = '0;
        case (ext_mode_e'(mode_i))
            EXT_ZERO:  ext_o = DATA_W'(const_i);
            EXT_SIGN:  ext_o = DATA_W'($signed(const_i));
            EXT_ZERO8: ext_o = DATA_W'(low8);
            EXT_SIGN8: ext_o = DATA_W'($signed(low8));
            // low byte placed at the bottom of the upper half
            EXT_HIGH:  ext_o = DATA_W'(low8) << (DATA_W / 2);
            default:   ext_o = '0;
        endcase
    end

endmodule

// File: rtl/id_rf_pipe.sv
// Decode / register-fetch stage: register file, link register, write-back mux, extender and a
// registered valid/ready operand stage toward EX. Define ID_RF_BYPASS_EN for same-edge write-to-read bypass.
module id_rf_pipe
    import id_rf_pkg::*;
#(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned NREGS   = 8,
    parameter  int unsigned CONST_W = 12,
    parameter  int unsigned R0_ZERO = 0,
    localparam int unsigned REG_AW  = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_AW-1:0]     sel_sa,
    input  logic [REG_AW-1:0]     sel_sb,
    input  logic [EXT_MODE_W-1:0] ext_mode,
    input  logic [CONST_W-1:0]    ext_const,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     a,
    output logic [DATA_W-1:0]     b,
    output logic [DATA_W-1:0]     const_ext,
    input  logic                  wb_en,
    input  logic [REG_AW-1:0]     wb_sel,
    input  logic [WB_SRC_W-1:0]   wb_src,
    input  logic [DATA_W-1:0]     res_ula,
    input  logic [DATA_W-1:0]     res_md,
    input  logic [DATA_W-1:0]     pc,
    input  logic                  pc_copy_en
);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] link_q;
    logic [DATA_W-1:0] wb_data;
    logic              wb_we;

    logic [DATA_W-1:0] rd_a, rd_b, ext_val;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic              out_valid_q, out_valid_d;
    logic              accept;

    id_rf_extender #(
        .DATA_W  (DATA_W),
        .CONST_W (CONST_W)
    ) u_ext (
        .mode_i  (ext_mode),
        .const_i (ext_const),
        .ext_o   (ext_val)
    );

    // link_q here is the value before this edge's pc_copy_en capture
    always_comb begin
        wb_data = '0;
        case (wb_src_e'(wb_src))
            WB_ULA:  wb_data = res_ula;
            WB_MD:   wb_data = res_md;
            WB_LINK: wb_data = link_q;
            default: wb_data = '0;
        endcase
        wb_we = wb_en && !((R0_ZERO != 0) && (wb_sel == '0));
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] sel);
        logic [DATA_W-1:0] v;
        v = rf_q[sel];
`ifdef ID_RF_BYPASS_EN
        if (wb_we && (wb_sel == sel)) v = wb_data;
`endif
        if ((R0_ZERO != 0) && (sel == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        rd_a = read_port(sel_sa);
        rd_b = read_port(sel_sb);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
            link_q <= '0;
        end else begin
            if (wb_we)      rf_q[wb_sel] <= wb_data;
            if (pc_copy_en) link_q       <= pc;
        end
    end

    // Operand stage: held while stalled, not refreshed by write-back.
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        accept      = in_valid && in_ready;
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        if (accept) begin
            out_valid_d = 1'b1;
            a_d         = rd_a;
            b_d         = rd_b;
            c_d         = ext_val;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = a_q;
    assign b         = b_q;
    assign const_ext = c_q;

endmodule
